ring_buffer_mc: RTL and testbench
=================================

// Module: ring_buffer_mc
// PURPOSE
//  Multi-channel generalisation of the team ring buffer: CHANNELS independent FIFOs, each with its own rx/tx handshake.
//  Per-channel occupancy, almost-full flag and synchronous flush. Depth need not be a power of 2.
//  Sits between a multi-port producer (e.g. router input lanes) and per-lane consumers.
//  First-word-fall-through: the head word is visible on data_o while tx_o is high.
// PARAMETERS
//  DATA_SIZE     32  width of one data word
//  BUFFER_SIZE   8   words per channel; any value >= 2
//  CHANNELS      4   number of independent FIFOs; >= 1
//  AFULL_THRESH  6   almost_full_o[c] is high when level >= AFULL_THRESH; range 1..BUFFER_SIZE
//  (derived) PTR_W = $clog2(BUFFER_SIZE), LVL_W = $clog2(BUFFER_SIZE+1)
// PORTS
//  clk_i          in   1                   clock; all logic on the rising edge
//  rst_i          in   1                   synchronous reset, active-high
//  rx_i           in   CHANNELS            per-channel write request
//  rx_ack_o       out  CHANNELS            per-channel ready, = !full[c]
//  data_i         in   CHANNELS*DATA_SIZE  write data; channel c at [c*DATA_SIZE +: DATA_SIZE]
//  tx_o           out  CHANNELS            per-channel valid, = !empty[c]
//  tx_ack_i       in   CHANNELS            per-channel consumer accept
//  data_o         out  CHANNELS*DATA_SIZE  head word of each channel, same packing as data_i
//  flush_i        in   CHANNELS            per-channel synchronous discard of all contents
//  level_o        out  CHANNELS*LVL_W      per-channel occupancy, 0..BUFFER_SIZE
//  almost_full_o  out  CHANNELS            level_o[c] >= AFULL_THRESH
// BEHAVIOUR
//  - Reset (rst_i=1 at clk edge): head=tail=0, level=0. So rx_ack_o=all 1, tx_o=all 0, almost_full_o=all 0, level_o=0.
//    Storage is not reset. data_o is don't-care while tx_o=0.
//  - Reset asserted mid-transfer wins over every other input in that cycle. All channels return to empty.
//  - Write on channel c: rx_i[c] && rx_ack_o[c]. Store data_i word at head[c]; advance head[c].
//  - Read on channel c: tx_o[c] && tx_ack_i[c]. Advance tail[c]. Word is consumed at that edge.
//  - rx_ack_o, tx_o, almost_full_o and level_o are registered or decoded from registers only.
//    There is no combinational path from rx_i or tx_ack_i to any output.
//  - data_o[c] = mem[c][tail[c]] combinationally from state. Latency: a word written at edge N is on data_o at N+1 if the channel was empty.
//  - Pointer wrap: a pointer equal to BUFFER_SIZE-1 advances to 0. Explicit compare, so non-power-of-2 depths work.
//  - level[c] next value:
//    +1 on write only; -1 on read only; unchanged on both or neither.
//    full = (level==BUFFER_SIZE); empty = (level==0).
//  - Simultaneous write+read, 0<level<BUFFER_SIZE: both occur and level is unchanged.
//  - Full: rx_ack_o[c]=0 even if tx_ack_i[c]=1 that cycle. A write is never accepted into a full channel.
//  - Empty: tx_o[c]=0, so a write and a read cannot pair. The write alone occurs.
//  - flush_i[c] at an edge: head[c]=tail[c]=0, level[c]=0. Any write or read on c in that cycle is discarded and not counted.
//    Other channels are unaffected.
//  - Channels are fully independent. No shared arbitration; all channels may transfer in the same cycle.
//  - No overflow or underflow is possible by construction. Assertions check level <= BUFFER_SIZE.
// TESTING
//  1. Reset, then write 0xA0..0xA7 to ch0 (BUFFER_SIZE=8), tx_ack=0.
//     -> level 1..8; almost_full rises when level reaches 6; rx_ack_o[0]=0 after the 8th word; 9th rx_i ignored.
//  2. Read ch0 from full with rx_i=1 and data 0xB0 held.
//     -> 0xA0 read, level 7, rx_ack back to 1 next cycle; 0xB0 enters only after rx_ack=1.
//  3. BUFFER_SIZE=5: push/pop 12 words, 0x00..0x0B, with rx_i and tx_ack_i=1 at steady level 2.
//     -> output order 0x00..0x0B exact; pointers wrap 4->0.
//  4. Empty ch1, rx_i=1 with 0x55 and tx_ack_i=1 the same cycle.
//     -> no read; next cycle tx_o[1]=1, data_o=0x55, level 1.
//  5. ch2 holds 3 words; flush_i[2]=1 with rx_i[2]=1 the same cycle.
//     -> level_o[2]=0, tx_o[2]=0; ch0/ch1/ch3 levels and data unchanged.
//  6. rst_i=1 for one cycle with all channels partially full.
//     -> all level 0, tx_o=0, rx_ack_o=1, almost_full_o=0 next cycle.

Source files
------------

// File: rtl/ring_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module   : ring_buffer_mc
// Purpose  : CHANNELS independent first-word-fall-through FIFOs with per-lane
//            handshakes, occupancy, almost-full flag and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module ring_buffer_mc #(
   parameter int DATA_SIZE    = 32,
   parameter int BUFFER_SIZE  = 8,
   parameter int CHANNELS     = 4,
   parameter int AFULL_THRESH = 6,
   localparam int PTR_W = $clog2(BUFFER_SIZE),
   localparam int LVL_W = $clog2(BUFFER_SIZE + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [CHANNELS-1:0]           rx_i,
   output logic [CHANNELS-1:0]           rx_ack_o,
   input  logic [CHANNELS*DATA_SIZE-1:0] data_i,
   output logic [CHANNELS-1:0]           tx_o,
   input  logic [CHANNELS-1:0]           tx_ack_i,
   output logic [CHANNELS*DATA_SIZE-1:0] data_o,
   input  logic [CHANNELS-1:0]           flush_i,
   output logic [CHANNELS*LVL_W-1:0]     level_o,
   output logic [CHANNELS-1:0]           almost_full_o
);

   localparam logic [LVL_W-1:0] c_FULL  = LVL_W'(BUFFER_SIZE);
   localparam logic [LVL_W-1:0] c_AFULL = LVL_W'(AFULL_THRESH);
   localparam logic [PTR_W-1:0] c_LAST  = PTR_W'(BUFFER_SIZE - 1);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [DATA_SIZE-1:0] r_mem [BUFFER_SIZE];
      logic [PTR_W-1:0]     r_head;
      logic [PTR_W-1:0]     r_tail;
      logic [LVL_W-1:0]     r_level;
      logic                 w_full;
      logic                 w_empty;
      logic                 w_wr;
      logic                 w_rd;

      assign w_full  = (r_level == c_FULL);
      assign w_empty = (r_level == '0);
      // Reset and flush take priority, so neither side of the handshake may commit.
      assign w_wr = rx_i[c]     && !w_full  && !rst_i && !flush_i[c];
      assign w_rd = tx_ack_i[c] && !w_empty && !rst_i && !flush_i[c];

      assign rx_ack_o[c]                        = !w_full;
      assign tx_o[c]                            = !w_empty;
      assign almost_full_o[c]                   = (r_level >= c_AFULL);
      assign level_o[c*LVL_W +: LVL_W]          = r_level;
      assign data_o[c*DATA_SIZE +: DATA_SIZE]   = r_mem[r_tail];

      always_ff @(posedge clk_i) begin
         if (w_wr) begin
            r_mem[r_head] <= data_i[c*DATA_SIZE +: DATA_SIZE];
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i || flush_i[c]) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
         end else begin
            // Explicit wrap compare keeps non-power-of-2 depths correct.
            if (w_wr) begin
               r_head <= (r_head == c_LAST) ? '0 : r_head + 1'b1;
            end
            if (w_rd) begin
               r_tail <= (r_tail == c_LAST) ? '0 : r_tail + 1'b1;
            end
            if (w_wr && !w_rd) begin
               r_level <= r_level + 1'b1;
            end else if (w_rd && !w_wr) begin
               r_level <= r_level - 1'b1;
            end
            assert (r_level <= c_FULL);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ring_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_buffer_mc
// Purpose  : Scenario bench for ring_buffer_mc against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_buffer_mc;

   localparam int A_CH = 4, A_DS = 32, A_BS = 8, A_AF = 6, A_LW = 4;
   localparam int B_CH = 2, B_DS = 8,  B_BS = 5, B_AF = 3, B_LW = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [A_CH-1:0]      a_rx = '0, a_tx_ack = '0, a_flush = '0;
   logic [A_CH*A_DS-1:0] a_din = '0;
   logic [A_CH-1:0]      a_rx_ack, a_tx, a_afull;
   logic [A_CH*A_DS-1:0] a_dout;
   logic [A_CH*A_LW-1:0] a_level;

   logic [B_CH-1:0]      b_rx = '0, b_tx_ack = '0, b_flush = '0;
   logic [B_CH*B_DS-1:0] b_din = '0;
   logic [B_CH-1:0]      b_rx_ack, b_tx, b_afull;
   logic [B_CH*B_DS-1:0] b_dout;
   logic [B_CH*B_LW-1:0] b_level;

   ring_buffer_mc #(.DATA_SIZE(A_DS), .BUFFER_SIZE(A_BS), .CHANNELS(A_CH), .AFULL_THRESH(A_AF)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .rx_i(a_rx), .rx_ack_o(a_rx_ack), .data_i(a_din),
      .tx_o(a_tx), .tx_ack_i(a_tx_ack), .data_o(a_dout), .flush_i(a_flush),
      .level_o(a_level), .almost_full_o(a_afull));

   ring_buffer_mc #(.DATA_SIZE(B_DS), .BUFFER_SIZE(B_BS), .CHANNELS(B_CH), .AFULL_THRESH(B_AF)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .rx_i(b_rx), .rx_ack_o(b_rx_ack), .data_i(b_din),
      .tx_o(b_tx), .tx_ack_i(b_tx_ack), .data_o(b_dout), .flush_i(b_flush),
      .level_o(b_level), .almost_full_o(b_afull));

   int n_checks = 0;
   int n_fail   = 0;
   logic [A_DS-1:0] mq [A_CH][$];

   // Advance one clock edge, applying the FIFO rules to the model for DUT A.
   task automatic tick();
      bit wr, rd;
      for (int c = 0; c < A_CH; c++) begin
         if (rst || a_flush[c]) begin
            mq[c].delete();
         end else begin
            wr = a_rx[c] && (mq[c].size() < A_BS);
            rd = a_tx_ack[c] && (mq[c].size() > 0);
            if (rd) void'(mq[c].pop_front());
            if (wr) mq[c].push_back(a_din[c*A_DS +: A_DS]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (a_rx_ack !== 4'hF) begin n_fail++; $display("FAIL reset_rx_ack got=%h exp=%h", a_rx_ack, 4'hF); end
      n_checks++; if (a_tx !== 4'h0) begin n_fail++; $display("FAIL reset_tx got=%h exp=0", a_tx); end
      n_checks++; if (a_afull !== 4'h0) begin n_fail++; $display("FAIL reset_afull got=%h exp=0", a_afull); end
      n_checks++; if (a_level !== '0) begin n_fail++; $display("FAIL reset_level got=%h exp=0", a_level); end
      n_checks++; if (b_rx_ack !== 2'b11 || b_tx !== 2'b00 || b_level !== '0) begin
         n_fail++; $display("FAIL reset_b got ack=%b tx=%b lvl=%h exp ack=11 tx=00 lvl=0", b_rx_ack, b_tx, b_level);
      end
   endtask

   task automatic test_fill();
      a_rx[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_din[0 +: 32] = 32'hA0 + i;
         tick();
         n_checks++; if (a_level[0 +: 4] !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_level got=%0d exp=%0d", a_level[0 +: 4], i + 1); end
         n_checks++; if (a_afull[0] !== (i + 1 >= 6)) begin n_fail++; $display("FAIL fill_afull lvl=%0d got=%b exp=%b", i + 1, a_afull[0], (i + 1 >= 6)); end
         n_checks++; if (a_rx_ack[0] !== (i + 1 < 8)) begin n_fail++; $display("FAIL fill_rx_ack lvl=%0d got=%b exp=%b", i + 1, a_rx_ack[0], (i + 1 < 8)); end
         n_checks++; if (a_dout[0 +: 32] !== 32'hA0 || a_tx[0] !== 1'b1) begin n_fail++; $display("FAIL fill_head got=%h tx=%b exp=a0 tx=1", a_dout[0 +: 32], a_tx[0]); end
      end
      a_din[0 +: 32] = 32'hA8;
      tick();
      n_checks++; if (a_level[0 +: 4] !== 4'd8 || a_dout[0 +: 32] !== 32'hA0) begin
         n_fail++; $display("FAIL fill_overflow got lvl=%0d head=%h exp lvl=8 head=a0", a_level[0 +: 4], a_dout[0 +: 32]);
      end
   endtask

   task automatic test_drain_full();
      logic [31:0] exp_seq [8];
      for (int i = 0; i < 7; i++) exp_seq[i] = 32'hA1 + i;
      exp_seq[7] = 32'hB0;
      a_rx[0] = 1'b1; a_din[0 +: 32] = 32'hB0; a_tx_ack[0] = 1'b1;
      n_checks++; if (a_dout[0 +: 32] !== 32'hA0) begin n_fail++; $display("FAIL drain_first got=%h exp=a0", a_dout[0 +: 32]); end
      tick();
      a_tx_ack[0] = 1'b0;
      n_checks++; if (a_level[0 +: 4] !== 4'd7 || a_rx_ack[0] !== 1'b1) begin
         n_fail++; $display("FAIL drain_level got lvl=%0d ack=%b exp lvl=7 ack=1", a_level[0 +: 4], a_rx_ack[0]);
      end
      tick();
      a_rx[0] = 1'b0;
      n_checks++; if (a_level[0 +: 4] !== 4'd8 || a_rx_ack[0] !== 1'b0) begin
         n_fail++; $display("FAIL drain_refill got lvl=%0d ack=%b exp lvl=8 ack=0", a_level[0 +: 4], a_rx_ack[0]);
      end
      a_tx_ack[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (a_dout[0 +: 32] !== exp_seq[i] || a_tx[0] !== 1'b1) begin
            n_fail++; $display("FAIL drain_order idx=%0d got=%h tx=%b exp=%h", i, a_dout[0 +: 32], a_tx[0], exp_seq[i]);
         end
         tick();
      end
      a_tx_ack[0] = 1'b0;
      n_checks++; if (a_level[0 +: 4] !== 4'd0 || a_tx[0] !== 1'b0) begin
         n_fail++; $display("FAIL drain_empty got lvl=%0d tx=%b exp lvl=0 tx=0", a_level[0 +: 4], a_tx[0]);
      end
   endtask

   task automatic test_wrap();
      int nin = 0, nout = 0;
      b_rx[0] = 1'b1;
      repeat (2) begin b_din[0 +: 8] = 8'(nin); nin++; tick(); end
      b_tx_ack[0] = 1'b1;
      while (nin < 12) begin
         b_din[0 +: 8] = 8'(nin);
         n_checks++; if (b_dout[0 +: 8] !== 8'(nout) || b_level[0 +: 3] !== 3'd2) begin
            n_fail++; $display("FAIL wrap_order got=%h lvl=%0d exp=%h lvl=2", b_dout[0 +: 8], b_level[0 +: 3], 8'(nout));
         end
         tick(); nin++; nout++;
      end
      b_rx[0] = 1'b0;
      while (nout < 12) begin
         n_checks++; if (b_dout[0 +: 8] !== 8'(nout)) begin n_fail++; $display("FAIL wrap_tail got=%h exp=%h", b_dout[0 +: 8], 8'(nout)); end
         tick(); nout++;
      end
      b_tx_ack[0] = 1'b0;
      n_checks++; if (b_level[0 +: 3] !== 3'd0 || b_tx[0] !== 1'b0) begin
         n_fail++; $display("FAIL wrap_empty got lvl=%0d tx=%b exp lvl=0 tx=0", b_level[0 +: 3], b_tx[0]);
      end
   endtask

   task automatic test_empty_pair();
      a_rx[1] = 1'b1; a_tx_ack[1] = 1'b1; a_din[32 +: 32] = 32'h55;
      tick();
      a_rx[1] = 1'b0; a_tx_ack[1] = 1'b0;
      n_checks++; if (a_tx[1] !== 1'b1 || a_dout[32 +: 32] !== 32'h55 || a_level[4 +: 4] !== 4'd1) begin
         n_fail++; $display("FAIL empty_pair got tx=%b data=%h lvl=%0d exp tx=1 data=55 lvl=1", a_tx[1], a_dout[32 +: 32], a_level[4 +: 4]);
      end
   endtask

   task automatic test_flush();
      a_rx = 4'b1101;
      for (int i = 0; i < 3; i++) begin
         a_din = {32'hD0 + i, 32'hC0 + i, 32'h0, 32'hE0 + i};
         if (i == 2) a_rx = 4'b0100;
         tick();
      end
      a_rx = 4'b0100; a_flush = 4'b0100; a_din[64 +: 32] = 32'hFF;
      tick();
      a_rx = '0; a_flush = '0;
      n_checks++; if (a_level[8 +: 4] !== 4'd0 || a_tx[2] !== 1'b0) begin
         n_fail++; $display("FAIL flush_ch2 got lvl=%0d tx=%b exp lvl=0 tx=0", a_level[8 +: 4], a_tx[2]);
      end
      for (int c = 0; c < A_CH; c++) begin
         if (c == 2) continue;
         n_checks++; if (a_level[c*4 +: 4] !== 4'(mq[c].size()) || a_dout[c*32 +: 32] !== mq[c][0]) begin
            n_fail++; $display("FAIL flush_other ch=%0d got lvl=%0d data=%h exp lvl=%0d data=%h",
                               c, a_level[c*4 +: 4], a_dout[c*32 +: 32], mq[c].size(), mq[c][0]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         a_rx = 4'($urandom); a_tx_ack = 4'($urandom);
         for (int c = 0; c < A_CH; c++) begin
            a_flush[c] = ($urandom_range(0, 15) == 0);
            a_din[c*32 +: 32] = $urandom;
         end
         tick();
         for (int c = 0; c < A_CH; c++) begin
            n_checks++;
            if (a_level[c*4 +: 4] !== 4'(mq[c].size()) || a_rx_ack[c] !== (mq[c].size() < A_BS) ||
                a_tx[c] !== (mq[c].size() > 0) || a_afull[c] !== (mq[c].size() >= A_AF) ||
                (mq[c].size() > 0 && a_dout[c*32 +: 32] !== mq[c][0])) begin
               n_fail++;
               $display("FAIL random cyc=%0d ch=%0d got lvl=%0d ack=%b tx=%b af=%b data=%h exp lvl=%0d data=%h",
                        n, c, a_level[c*4 +: 4], a_rx_ack[c], a_tx[c], a_afull[c], a_dout[c*32 +: 32],
                        mq[c].size(), (mq[c].size() > 0) ? mq[c][0] : 32'h0);
            end
         end
      end
      a_rx = '0; a_tx_ack = '0; a_flush = '0;
   endtask

   task automatic test_reset_mid();
      a_rx = 4'hF;
      for (int i = 0; i < 3; i++) begin a_din = {4{$urandom}}; tick(); end
      b_rx = 2'b11; tick();
      a_tx_ack = 4'hF; b_tx_ack = 2'b11; rst = 1'b1;
      tick();
      rst = 1'b0; a_rx = '0; a_tx_ack = '0; b_rx = '0; b_tx_ack = '0;
      n_checks++; if (a_level !== '0 || a_tx !== 4'h0 || a_rx_ack !== 4'hF || a_afull !== 4'h0) begin
         n_fail++; $display("FAIL reset_mid_a got lvl=%h tx=%h ack=%h af=%h exp 0/0/f/0", a_level, a_tx, a_rx_ack, a_afull);
      end
      n_checks++; if (b_level !== '0 || b_tx !== 2'b00 || b_rx_ack !== 2'b11) begin
         n_fail++; $display("FAIL reset_mid_b got lvl=%h tx=%b ack=%b exp 0/00/11", b_level, b_tx, b_rx_ack);
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_fill();
      test_drain_full();
      test_wrap();
      test_empty_pair();
      test_flush();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
